// File: rtl/ascent_pkg.sv
// Shared phase encodings, output flag bundle and default flight constants
// for the ascent sequencer.
package ascent_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNT     = 3'd1,
    S1_BURN   = 3'd2,
    S1_GIMBAL = 3'd3,
    SEP       = 3'd4,
    S2_BURN   = 3'd5,
    ORBIT     = 3'd6,
    ABORT     = 3'd7
  } phase_t;

  typedef struct packed {
    logic launch_ack;
    logic ignition;
    logic engine_sel;
    logic gimbal_en;
    logic stage_sep;
    logic orbit_done;
    logic abort_flag;
  } flags_t;

  localparam int              DEF_N           = 64;
  localparam longint unsigned DEF_GIMBAL_ALT  = 64'd30_000_000;
  localparam longint unsigned DEF_ORBIT_ALT   = 64'd188_000_000;
  localparam longint unsigned DEF_ORBIT_VEL   = 64'd7_800_000;
  localparam int              DEF_COUNT_CYC   = 10;
  localparam int              DEF_CONFIRM_CYC = 4;
  localparam int              DEF_S1_BURN_CYC = 200;
  localparam int              DEF_SEP_CYC     = 8;
  localparam int              DEF_S2_TIMEOUT  = 5000;

  function automatic int max_of(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ascent_sequencer_if.sv
// Trajectory inputs and flight-phase outputs of the ascent sequencer.
interface ascent_sequencer_if #(
  parameter int N = 64
);
  logic         launch_req;
  logic         abort_req;
  logic [N-1:0] height;
  logic [N-1:0] velocity;
  logic         launch_ack;
  logic [2:0]   phase;
  logic         ignition;
  logic         engine_sel;
  logic         gimbal_en;
  logic         stage_sep;
  logic         orbit_done;
  logic         abort_flag;

  modport master (
    output launch_req, abort_req, height, velocity,
    input  launch_ack, phase, ignition, engine_sel, gimbal_en,
           stage_sep, orbit_done, abort_flag
  );

  modport slave (
    input  launch_req, abort_req, height, velocity,
    output launch_ack, phase, ignition, engine_sel, gimbal_en,
           stage_sep, orbit_done, abort_flag
  );
endinterface

// File: rtl/ascent_sequencer_confirm.sv
// Debounces a threshold condition: hit asserts on the CONFIRM_CYC-th
// consecutive cycle that cond holds; any false cycle or clear restarts.
module threshold_confirm #(
  parameter int CONFIRM_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cond,
  input  logic clear,
  output logic hit
);
  localparam int W = $clog2(CONFIRM_CYC + 1);
  localparam logic [W-1:0] SAT    = W'(CONFIRM_CYC);
  localparam logic [W-1:0] HIT_AT = W'(CONFIRM_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || !cond) begin
      cnt <= '0;
    end else if (cnt != SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = cond && (cnt >= HIT_AT);
endmodule

// File: rtl/ascent_sequencer.sv
// Flight-phase controller: countdown, S1 burn, gimbal enable, separation,
// S2 burn and orbit insertion, with abort overriding every active phase.
module ascent_sequencer
  import ascent_pkg::*;
#(
  parameter int              N           = DEF_N,
  parameter longint unsigned GIMBAL_ALT  = DEF_GIMBAL_ALT,
  parameter longint unsigned ORBIT_ALT   = DEF_ORBIT_ALT,
  parameter longint unsigned ORBIT_VEL   = DEF_ORBIT_VEL,
  parameter int              COUNT_CYC   = DEF_COUNT_CYC,
  parameter int              CONFIRM_CYC = DEF_CONFIRM_CYC,
  parameter int              S1_BURN_CYC = DEF_S1_BURN_CYC,
  parameter int              SEP_CYC     = DEF_SEP_CYC,
  parameter int              S2_TIMEOUT  = DEF_S2_TIMEOUT
) (
  input logic              clk,
  input logic              reset,
  ascent_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(max_of(COUNT_CYC, S1_BURN_CYC, SEP_CYC, S2_TIMEOUT)) + 1;
  localparam logic [N-1:0]     GIMBAL_TH = N'(GIMBAL_ALT);
  localparam logic [N-1:0]     ORBIT_TH  = N'(ORBIT_ALT);
  localparam logic [N-1:0]     VEL_TH    = N'(ORBIT_VEL);
  localparam logic [CNT_W-1:0] COUNT_TC  = CNT_W'(COUNT_CYC - 1);
  localparam logic [CNT_W-1:0] S1_TC     = CNT_W'(S1_BURN_CYC - 1);
  localparam logic [CNT_W-1:0] SEP_TC    = CNT_W'(SEP_CYC - 1);
  localparam logic [CNT_W-1:0] S2_TC     = CNT_W'(S2_TIMEOUT - 1);

  phase_t           state, next_state;
  flags_t           flags_q, flags_d;
  logic [CNT_W-1:0] cyc_cnt;
  logic             state_change, timed, abort_ok;
  logic             gimbal_cond, orbit_cond, gimbal_hit, orbit_hit;

  assign state_change = (next_state != state);
  assign timed        = state inside {COUNT, S1_GIMBAL, SEP, S2_BURN};
  assign abort_ok     = state inside {COUNT, S1_BURN, S1_GIMBAL, SEP, S2_BURN};
  assign gimbal_cond  = (state == S1_BURN) && (bus.height > GIMBAL_TH);
  assign orbit_cond   = (state == S2_BURN) && (bus.height >= ORBIT_TH) &&
                        (bus.velocity >= VEL_TH);

  threshold_confirm #(.CONFIRM_CYC(CONFIRM_CYC)) u_gimbal_confirm (
    .clk(clk), .reset(reset), .cond(gimbal_cond), .clear(state_change), .hit(gimbal_hit)
  );

  threshold_confirm #(.CONFIRM_CYC(CONFIRM_CYC)) u_orbit_confirm (
    .clk(clk), .reset(reset), .cond(orbit_cond), .clear(state_change), .hit(orbit_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      flags_q <= '0;
      cyc_cnt <= '0;
    end else begin
      state   <= next_state;
      flags_q <= flags_d;
      cyc_cnt <= (state_change || !timed) ? '0 : cyc_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (bus.abort_req && abort_ok) begin
      next_state = ABORT;
    end else begin
      case (state)
        IDLE:      if (bus.launch_req) next_state = COUNT;
        COUNT:     if (cyc_cnt == COUNT_TC) next_state = S1_BURN;
        S1_BURN:   if (gimbal_hit) next_state = S1_GIMBAL;
        S1_GIMBAL: if (cyc_cnt == S1_TC) next_state = SEP;
        SEP:       if (cyc_cnt == SEP_TC) next_state = S2_BURN;
        // Timeout outranks a same-cycle orbit confirmation.
        S2_BURN:   if (cyc_cnt == S2_TC) next_state = ABORT;
                   else if (orbit_hit) next_state = ORBIT;
        default:   next_state = state;
      endcase
    end
  end

  // Output flags change only on phase entry, so they stay aligned with phase.
  always_comb begin
    flags_d            = flags_q;
    flags_d.launch_ack = 1'b0;
    flags_d.stage_sep  = 1'b0;
    if (state_change) begin
      case (next_state)
        COUNT:     flags_d.launch_ack = 1'b1;
        S1_BURN:   begin flags_d.ignition = 1'b1; flags_d.engine_sel = 1'b0; end
        S1_GIMBAL: flags_d.gimbal_en = 1'b1;
        SEP:       begin
          flags_d.ignition  = 1'b0;
          flags_d.gimbal_en = 1'b0;
          flags_d.stage_sep = 1'b1;
        end
        S2_BURN:   begin
          flags_d.ignition   = 1'b1;
          flags_d.engine_sel = 1'b1;
          flags_d.gimbal_en  = 1'b1;
        end
        ORBIT:     begin
          flags_d.ignition   = 1'b0;
          flags_d.gimbal_en  = 1'b0;
          flags_d.orbit_done = 1'b1;
        end
        ABORT:     begin
          flags_d.ignition   = 1'b0;
          flags_d.gimbal_en  = 1'b0;
          flags_d.abort_flag = 1'b1;
        end
        default:   flags_d = flags_d;
      endcase
    end
  end

  assign bus.phase      = state;
  assign bus.launch_ack = flags_q.launch_ack;
  assign bus.ignition   = flags_q.ignition;
  assign bus.engine_sel = flags_q.engine_sel;
  assign bus.gimbal_en  = flags_q.gimbal_en;
  assign bus.stage_sep  = flags_q.stage_sep;
  assign bus.orbit_done = flags_q.orbit_done;
  assign bus.abort_flag = flags_q.abort_flag;
endmodule

// File: tb/tb_ascent_sequencer.sv
// Directed/randomized bench for ascent_sequencer checked every cycle against
// a phase-level flight model.
module tb_ascent_sequencer;
  localparam longint unsigned G_ALT   = 64'd30_000_000;
  localparam longint unsigned O_ALT   = 64'd188_000_000;
  localparam longint unsigned O_VEL   = 64'd7_800_000;
  localparam int              CNT_CYC = 10;
  localparam int              CONFIRM = 4;
  localparam int              S1_CYC  = 200;
  localparam int              SEP_CY  = 8;
  localparam int              S2_TO   = 5000;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  // model: phase, cycles already spent in it, consecutive-threshold streak
  int m_phase, m_prev, m_dwell, m_streak;
  bit m_engine;

  ascent_sequencer_if #(.N(64)) bus ();

  ascent_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {bus.phase, bus.launch_ack, bus.ignition, bus.engine_sel, bus.gimbal_en,
            bus.stage_sep, bus.orbit_done, bus.abort_flag};
  endfunction

  function automatic logic [9:0] exp_vec();
    logic ack, ign, gim, sep, orb, abt;
    ack = (m_phase == 1) && (m_prev == 0);
    ign = (m_phase == 2) || (m_phase == 3) || (m_phase == 5);
    gim = (m_phase == 3) || (m_phase == 5);
    sep = (m_phase == 4) && (m_prev != 4);
    orb = (m_phase == 6);
    abt = (m_phase == 7);
    return {3'(m_phase), ack, ign, m_engine, gim, sep, orb, abt};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prev = 0; m_dwell = 0; m_streak = 0; m_engine = 1'b0;
  endtask

  task automatic model_step();
    int np;
    np = m_phase;
    if (bus.abort_req && m_phase >= 1 && m_phase <= 5) np = 7;
    else begin
      case (m_phase)
        0: if (bus.launch_req) np = 1;
        1: if (m_dwell + 1 == CNT_CYC) np = 2;
        2: begin
          m_streak = (bus.height > G_ALT) ? m_streak + 1 : 0;
          if (m_streak >= CONFIRM) np = 3;
        end
        3: if (m_dwell + 1 == S1_CYC) np = 4;
        4: if (m_dwell + 1 == SEP_CY) np = 5;
        5: begin
          m_streak = (bus.height >= O_ALT && bus.velocity >= O_VEL) ? m_streak + 1 : 0;
          if (m_dwell + 1 == S2_TO) np = 7;
          else if (m_streak >= CONFIRM) np = 6;
        end
        default: np = m_phase;
      endcase
    end
    m_prev = m_phase;
    if (np != m_phase) begin m_dwell = 0; m_streak = 0; end
    else m_dwell++;
    if (np == 5) m_engine = 1'b1;
    m_phase = np;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check($sformatf("cycle_ph%0d", m_phase), 64'(obs_vec()), 64'(exp_vec()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_async", 64'(obs_vec()), 64'(exp_vec()));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && m_phase != target; i++) step();
    check(tag, 64'(bus.phase), 64'(target));
  endtask

  task automatic launch();
    bus.launch_req = 1'b1;
    step();
    bus.launch_req = 1'b0;
  endtask

  task automatic ramp_step();
    bus.height   = bus.height + 64'($urandom_range(1_500_000, 500_000));
    bus.velocity = bus.velocity + 64'($urandom_range(60_000, 20_000));
    if (bus.height > 64'd200_000_000) bus.height = 64'd200_000_000;
    if (bus.velocity > 64'd8_000_000) bus.velocity = 64'd8_000_000;
    step();
  endtask

  initial begin
    int acks, seps, hit_at;
    logic [7:0] seen;
    reset = 1'b0;
    bus.launch_req = 1'b0;
    bus.abort_req  = 1'b0;
    bus.height     = '0;
    bus.velocity   = '0;
    model_reset();
    #2;
    do_reset();

    // abort in IDLE is ignored
    bus.abort_req = 1'b1;
    bus.height    = 64'($urandom_range(50_000_000, 0));
    repeat (3) step();
    bus.abort_req = 1'b0;
    bus.height    = '0;
    check("idle_abort_ignored", 64'(bus.phase), 64'd0);

    // nominal flight
    acks = 0; seps = 0; seen = '0;
    bus.launch_req = 1'b1;
    step();
    bus.launch_req = 1'b0;
    if (bus.launch_ack) acks++;
    seen[bus.phase] = 1'b1;
    for (int i = 0; i < 3000 && m_phase != 6; i++) begin
      ramp_step();
      if (bus.launch_ack) acks++;
      if (bus.stage_sep) seps++;
      seen[bus.phase] = 1'b1;
    end
    check("nominal_phase", 64'(bus.phase), 64'd6);
    check("nominal_phases_seen", 64'(seen), 64'h7E);
    check("nominal_ack_pulses", 64'(acks), 64'd1);
    check("nominal_sep_pulses", 64'(seps), 64'd1);
    check("nominal_orbit_done", 64'(bus.orbit_done), 64'd1);
    bus.launch_req = 1'b1;
    bus.abort_req  = 1'b1;
    repeat (3) step();
    bus.launch_req = 1'b0;
    bus.abort_req  = 1'b0;
    check("orbit_terminal", 64'(bus.phase), 64'd6);

    // glitch and exact-threshold in S1_BURN, then abort at burnout
    do_reset();
    bus.height = '0; bus.velocity = '0;
    launch();
    run_until(2, 20, "reach_s1_burn");
    bus.height = 64'd30_000_001;
    repeat (3) step();
    bus.height = 64'd29_000_000;
    repeat (5) step();
    check("glitch_phase", 64'(bus.phase), 64'd2);
    check("glitch_gimbal", 64'(bus.gimbal_en), 64'd0);
    bus.height = G_ALT;
    repeat (10) step();
    check("exact_gimbal_alt_phase", 64'(bus.phase), 64'd2);
    check("exact_gimbal_alt_gimbal", 64'(bus.gimbal_en), 64'd0);
    repeat (4) begin
      bus.height = G_ALT + 64'($urandom_range(5_000_000, 1));
      step();
    end
    check("gimbal_phase", 64'(bus.phase), 64'd3);
    check("gimbal_en", 64'(bus.gimbal_en), 64'd1);
    repeat (S1_CYC - 1) step();
    bus.abort_req = 1'b1;
    step();
    check("abort_at_burnout_phase", 64'(bus.phase), 64'd7);
    check("abort_at_burnout_ign", 64'(bus.ignition), 64'd0);
    check("abort_at_burnout_flag", 64'(bus.abort_flag), 64'd1);
    check("abort_at_burnout_sep", 64'(bus.stage_sep), 64'd0);
    bus.abort_req  = 1'b0;
    bus.launch_req = 1'b1;
    repeat (2) step();
    bus.launch_req = 1'b0;
    check("abort_terminal", 64'(bus.phase), 64'd7);

    // reset pulse during SEP
    do_reset();
    launch();
    bus.height = 64'd50_000_000;
    run_until(4, 300, "reach_sep");
    repeat (3) step();
    do_reset();
    check("sep_reset_phase", 64'(bus.phase), 64'd0);

    // S2 stuck below orbit altitude -> timeout abort
    launch();
    run_until(5, 300, "reach_s2_timeout_run");
    bus.height = 64'd100_000_000;
    hit_at = -1;
    for (int i = 1; i <= S2_TO + 5; i++) begin
      bus.velocity = 64'($urandom_range(9_000_000, 0));
      step();
      if (bus.phase == 3'd7) begin hit_at = i; break; end
    end
    check("s2_timeout_cycles", 64'(hit_at), 64'(S2_TO));
    check("s2_timeout_flag", 64'(bus.abort_flag), 64'd1);

    // exact orbit thresholds
    do_reset();
    bus.velocity = '0;
    launch();
    bus.height = 64'd50_000_000;
    run_until(5, 300, "reach_s2_boundary_run");
    bus.height = O_ALT - 64'd1; bus.velocity = O_VEL;
    repeat (2) step();
    bus.height = O_ALT; bus.velocity = O_VEL - 64'd1;
    repeat (2) step();
    bus.velocity = O_VEL;
    repeat (3) step();
    check("orbit_exact_3cyc", 64'(bus.phase), 64'd5);
    step();
    check("orbit_exact_4cyc", 64'(bus.phase), 64'd6);
    check("orbit_exact_done", 64'(bus.orbit_done), 64'd1);

    // random abort during countdown
    do_reset();
    launch();
    repeat ($urandom_range(8, 0)) step();
    bus.abort_req = 1'b1;
    step();
    bus.abort_req = 1'b0;
    check("count_abort_phase", 64'(bus.phase), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
